led_spi_tx: RTL and testbench

LED_SPI_TX -- requirements
Module: led_spi_tx

---
 rtl/led_matrix_pkg.sv | 44 ++++
 rtl/led_spi_phase_timer.sv | 29 ++
 rtl/led_spi_tx.sv | 193 +++++++++++++++++++
 tb/tb_led_spi_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the LED matrix SPI link: FSM state encoding,
// word field positions, default timing and word-building helpers.
package led_matrix_pkg;

    localparam int unsigned STATE_W     = 3;
    localparam int unsigned ADDR_MSB    = 29;
    localparam int unsigned ADDR_LSB    = 24;
    localparam int unsigned RGB_MSB     = 23;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned CLK_DIV_DEF = 25;
    localparam int unsigned CS_GAP_DEF  = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_TRAIL = 3'd4,
        S_GAP   = 3'd5
    } state_e;

    typedef struct packed {
        logic [5:0]  addr;
        logic [23:0] rgb;
    } pixel_t;

    // Two pad bits, address, then colour; shifted MSB first.
    function automatic logic [WORD_W-1:0] make_word(input pixel_t pix);
        logic [WORD_W-1:0] w;
        w                    = '0;
        w[ADDR_MSB:ADDR_LSB] = pix.addr;
        w[RGB_MSB:0]         = pix.rgb;
        return w;
    endfunction

    // Row drives red, column drives green, blue fixed at half scale.
    function automatic pixel_t pattern_pixel(input logic [5:0] a);
        pixel_t p;
        p.addr = a;
        p.rgb  = {a[2:0], 5'b0, a[5:3], 5'b0, 8'h80};
        return p;
    endfunction

endpackage

// File: rtl/led_spi_phase_timer.sv
// Counts CLK_DIV cycles per SPI phase and strobes tc_c on the last cycle;
// clears while idle and on restart so each phase starts from zero.
module led_spi_phase_timer
    import led_matrix_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic tc_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tc_c = run && (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst || restart || !run || tc_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_spi_tx.sv
// SPI mode-0 transmitter for 32-bit LED pixel words {2'b00, addr, rgb}.
// Optional test-pattern source compiled in with LED_SPI_TX_TESTPAT_EN.
module led_spi_tx
    import led_matrix_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned CS_GAP  = CS_GAP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [5:0]  pix_addr,
    input  logic [23:0] pix_rgb,
    input  logic        test_en,
    output logic        sclk,
    output logic        mosi,
    output logic        cs,
    output logic        busy,
    output logic        word_done
);

    localparam logic [STATE_W-1:0] ST_IDLE  = S_IDLE;
    localparam logic [STATE_W-1:0] ST_LEAD  = S_LEAD;
    localparam logic [STATE_W-1:0] ST_HIGH  = S_HIGH;
    localparam logic [STATE_W-1:0] ST_LOW   = S_LOW;
    localparam logic [STATE_W-1:0] ST_TRAIL = S_TRAIL;
    localparam logic [STATE_W-1:0] ST_GAP   = S_GAP;

    localparam int unsigned BIT_W = 5;
    localparam int unsigned GAP_W = $clog2(CS_GAP);

    logic [STATE_W-1:0] state, state_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic [WORD_W-1:0]  word, word_nxt;
    logic               sclk_nxt, mosi_nxt, cs_nxt;
    logic               ready_nxt, busy_nxt, done_nxt;

    logic               accept_c;
    logic               pat_mode_c;
    logic [WORD_W-1:0]  src_word_c;
    logic               run_c;
    logic               tc_c;
    pixel_t             pix_c;

    assign pix_c = '{addr: pix_addr, rgb: pix_rgb};

`ifdef LED_SPI_TX_TESTPAT_EN
    logic [5:0] pat_addr;

    // In pattern mode the block feeds itself from a wrapping address counter.
    always_comb begin
        pat_mode_c = test_en;
        accept_c   = (state == ST_IDLE) && (test_en || (pix_valid && pix_ready));
        src_word_c = test_en ? make_word(pattern_pixel(pat_addr)) : make_word(pix_c);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_addr <= '0;
        end else if (accept_c && test_en) begin
            pat_addr <= pat_addr + 6'(1);
        end
    end
`else
    logic test_en_unused;

    assign test_en_unused = test_en;

    always_comb begin
        pat_mode_c = 1'b0;
        accept_c   = pix_valid && pix_ready;
        src_word_c = make_word(pix_c);
    end
`endif

    assign run_c = (state != ST_IDLE) && (state != ST_GAP);

    led_spi_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (run_c),
        .restart (accept_c),
        .tc_c    (tc_c)
    );

    // Next-state and next-output logic; every output leaves through a register.
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        gap_nxt   = gap_cnt;
        word_nxt  = word;
        sclk_nxt  = sclk;
        mosi_nxt  = mosi;
        cs_nxt    = cs;
        done_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                cs_nxt   = 1'b1;
                sclk_nxt = 1'b0;
                mosi_nxt = 1'b0;
                if (accept_c) begin
                    word_nxt  = src_word_c;
                    bit_nxt   = BIT_W'(WORD_W - 1);
                    cs_nxt    = 1'b0;
                    mosi_nxt  = src_word_c[WORD_W-1];
                    state_nxt = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (tc_c) begin
                    sclk_nxt  = 1'b1;
                    state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tc_c) begin
                    sclk_nxt = 1'b0;
                    if (bit_cnt == '0) begin
                        state_nxt = ST_TRAIL;
                    end else begin
                        bit_nxt   = bit_cnt - BIT_W'(1);
                        mosi_nxt  = word[bit_cnt - BIT_W'(1)];
                        state_nxt = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (tc_c) begin
                    sclk_nxt  = 1'b1;
                    state_nxt = ST_HIGH;
                end
            end
            ST_TRAIL: begin
                if (tc_c) begin
                    cs_nxt    = 1'b1;
                    mosi_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    gap_nxt   = '0;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
                    gap_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                cs_nxt    = 1'b1;
                sclk_nxt  = 1'b0;
                mosi_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase

        ready_nxt = (state_nxt == ST_IDLE) && !pat_mode_c;
        busy_nxt  = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            word      <= '0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            cs        <= 1'b1;
            pix_ready <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_nxt;
            gap_cnt   <= gap_nxt;
            word      <= word_nxt;
            sclk      <= sclk_nxt;
            mosi      <= mosi_nxt;
            cs        <= cs_nxt;
            pix_ready <= ready_nxt;
            busy      <= busy_nxt;
            word_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_led_spi_tx.sv
// Directed bench for led_spi_tx at CLK_DIV=4, CS_GAP=4: table of pixel words
// plus hand-written reset, back-to-back and test-pattern sequences.
module tb_led_spi_tx;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned CS_GAP  = 4;
    localparam int unsigned LAT     = 65 * CLK_DIV + CS_GAP;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_valid = 1'b0;
    logic [5:0]  pix_addr = '0;
    logic [23:0] pix_rgb = '0;
    logic        test_en = 1'b0;
    logic        pix_ready, sclk, mosi, cs, busy, word_done;

    led_spi_tx #(
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_addr  (pix_addr),
        .pix_rgb   (pix_rgb),
        .test_en   (test_en),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs        (cs),
        .busy      (busy),
        .word_done (word_done)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SPI receiver model: samples mosi on each sclk rise, one word per word_done.
    logic [31:0] shreg = '0;
    logic        sclk_q = 1'b0, cs_q = 1'b1, mosi_q = 1'b0;
    int          rise_total = 0, word_rises = 0, done_total = 0;
    int          cs_run = 0, min_gap = 1000, cs_err = 0, stab_err = 0;
    logic [31:0] rx_q[$];
    int          rises_q[$];

    always @(negedge clk) begin
        if (cs_q === 1'b1 && cs === 1'b0) begin
            if (cs_run < min_gap) min_gap = cs_run;
            shreg      = '0;
            word_rises = 0;
        end
        cs_run = (cs === 1'b1) ? cs_run + 1 : 0;
        if (sclk === 1'b1 && sclk_q === 1'b0) begin
            rise_total++;
            word_rises++;
            shreg = {shreg[30:0], mosi};
            if (cs !== 1'b0) cs_err++;
        end
        if (cs === 1'b0 && cs_q === 1'b0 && sclk === sclk_q && mosi !== mosi_q) stab_err++;
        if (word_done === 1'b1) begin
            done_total++;
            rx_q.push_back(shreg);
            rises_q.push_back(word_rises);
        end
        sclk_q = sclk;
        cs_q   = cs;
        mosi_q = mosi;
    end

    typedef struct {
        logic [5:0]  addr;
        logic [23:0] rgb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic wait_ready(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (pix_ready === 1'b1) got = 1'b1;
        end
        if (!got) check(name, 32'(got), 32'd1);
    endtask

    // Offer one pixel, then scramble the inputs until pix_ready returns.
    task automatic send(input logic [5:0] a, input logic [23:0] c, output int lat);
        bit done;
        wait_ready("ready_before_send");
        pix_valid = 1'b1;
        pix_addr  = a;
        pix_rgb   = c;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        lat  = 0;
        done = 1'b0;
        for (int i = 1; i <= 2000 && !done; i++) begin
            pix_addr  = 6'($urandom);
            pix_rgb   = 24'($urandom);
            pix_valid = 1'($urandom);
            @(posedge clk);
            #1;
            if (pix_ready === 1'b1) begin
                lat       = i;
                pix_valid = 1'b0;
                done      = 1'b1;
            end
        end
        pix_valid = 1'b0;
    endtask

    function automatic logic [31:0] pat_word(input logic [5:0] a);
        logic [31:0] w;
        w = {2'b00, a, a[2:0], 5'b0, a[5:3], 5'b0, 8'h80};
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, dbase, rbase, rises;
        bit          got;
        logic [31:0] w, w63;

        vecs[0] = '{6'd9,  24'hA05F30, 32'h09A05F30};
        vecs[1] = '{6'd63, 24'hFFFFFF, 32'h3FFFFFFF};
        vecs[2] = '{6'd0,  24'h000000, 32'h00000000};
        vecs[3] = '{6'd42, 24'h123456, 32'h2A123456};
        vecs[4] = '{6'd21, 24'h800001, 32'h15800001};
        w63 = 'x;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({cs, sclk, mosi, busy, pix_ready, word_done}), 32'b100000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_first_edge", 32'(pix_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            rx_q.delete();
            rises_q.delete();
            send(vecs[i].addr, vecs[i].rgb, lat);
            check($sformatf("vec%0d_ready_latency", i), 32'(lat), 32'(LAT));
            w     = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
            rises = (rises_q.size() > 0) ? rises_q.pop_front() : -1;
            check($sformatf("vec%0d_word", i), w, vecs[i].exp);
            check($sformatf("vec%0d_sclk_rises", i), 32'(rises), 32'd32);
            if (vecs[i].addr == 6'd63) w63 = w;
        end
        check("loopback_addr63_rgb_nibbles", 32'({w63[29:24], w63[23:20], w63[15:12], w63[7:4]}),
              32'({6'd63, 4'hF, 4'hF, 4'hF}));

        // Three words with pix_valid held high throughout.
        wait_ready("ready_before_b2b");
        rx_q.delete();
        rises_q.delete();
        dbase   = done_total;
        rbase   = rise_total;
        min_gap = 1000;
        pix_valid = 1'b1;
        pix_addr  = 6'd33;
        pix_rgb   = 24'h00FF00;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clk);
            if (done_total >= dbase + 3) got = 1'b1;
        end
        #1;
        pix_valid = 1'b0;
        check("b2b_done_pulses", 32'(done_total - dbase), 32'd3);
        check("b2b_sclk_rises", 32'(rise_total - rbase), 32'd96);
        check("b2b_cs_gap_at_least_4", 32'(min_gap >= int'(CS_GAP)), 32'd1);
        for (int k = 0; k < 3; k++) begin
            w = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
            check($sformatf("b2b_word%0d", k), w, 32'h2100FF00);
        end

        // Reset asserted after the 10th sclk rise of a word.
        wait_ready("ready_before_rst");
        dbase = done_total;
        rbase = rise_total;
        pix_valid = 1'b1;
        pix_addr  = 6'd7;
        pix_rgb   = 24'h123456;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            if (rise_total >= rbase + 10) got = 1'b1;
        end
        check("rst_reached_10_rises", 32'(got), 32'd1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_outputs", 32'({cs, sclk, mosi, busy, pix_ready, word_done}), 32'b100000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_ready", 32'(pix_ready), 32'd1);
        repeat (300) @(posedge clk);
        check("rst_no_word_done", 32'(done_total - dbase), 32'd0);

`ifdef LED_SPI_TX_TESTPAT_EN
        wait_ready("ready_before_pattern");
        rx_q.delete();
        dbase = done_total;
        test_en = 1'b1;
        @(posedge clk);
        #1;
        check("tp_ready_low", 32'(pix_ready), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 65 * 300 && !got; i++) begin
            @(posedge clk);
            if (done_total >= dbase + 65) got = 1'b1;
        end
        #1;
        test_en = 1'b0;
        check("tp_word_count", 32'(done_total - dbase), 32'd65);
        for (int k = 0; k < 65; k++) begin
            w = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
            check($sformatf("tp_word%0d", k), w, pat_word(6'(k % 64)));
            if (k == 5) check("tp_word_a5_literal", w, 32'h05A00080);
        end
`else
        wait_ready("ready_before_test_en");
        test_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("test_en_ignored_busy", 32'(busy), 32'd0);
        check("test_en_ignored_ready", 32'(pix_ready), 32'd1);
        test_en = 1'b0;
`endif

        check("sclk_rise_with_cs_high", 32'(cs_err), 32'd0);
        check("mosi_stable_within_phase", 32'(stab_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
